ulpb_tx_sequencer: RTL and testbench
====================================

Name: ulpb_tx_sequencer

Overview:
Upstream feeder for the 32-bit bus node's transmit interface. A layer controller loads a message (one address plus 1..DEPTH data words) into a local word buffer and pulses start. The block then drives the node's TX_REQ/TX_ACK word handshake with correct TX_PEND chaining, consumes the TX_SUCC/TX_FAIL response with TX_RESP_ACK, and retries failed messages. It reports completion to the controller as a one-cycle DONE with a status code.

Parameters:
DEPTH, 8, buffer depth in data words (power of 2, ≥2); pointers log2(DEPTH)+1 bits
MAX_RETRY, 2, re-sends after a TX_FAIL before reporting failure (0 = no retry)
TIMEOUT, 1024, cycles allowed waiting for TX_ACK on any word (only with the optional feature)

Ports:
CLK  in  1  clock
RESET  in  1  reset, synchronous, active-high
WR_EN  in  1  push WR_DATA into the buffer
WR_DATA  in  `DATA_WIDTH  data word
FULL  out  1  buffer holds DEPTH words
MSG_ADDR  in  `ADDR_WIDTH  destination address, latched on START
START  in  1  single-cycle request to send the buffered message
BUSY  out  1  message in progress
DONE  out  1  single-cycle completion pulse
STATUS  out  2  valid with DONE: 00 ok, 01 fail (retries exhausted), 10 timeout
TX_ADDR  out  `ADDR_WIDTH  to node
TX_DATA  out  `DATA_WIDTH  to node
TX_PEND  out  1  to node: more words follow the current one
TX_REQ  out  1  to node
TX_ACK  in  1  from node
TX_SUCC  in  1  from node
TX_FAIL  in  1  from node
TX_RESP_ACK  out  1  to node

Behaviour:
- Reset: all outputs 0, state IDLE, wr_ptr=rd_ptr=retry_cnt=0. Reset mid-message drops TX_REQ on the next edge. Buffer contents are don't-care.
- Writes: WR_EN writes buf[wr_ptr] and increments wr_ptr only when IDLE and not FULL. Otherwise the write is dropped. FULL = (wr_ptr==DEPTH).
- IDLE: START with wr_ptr≠0 latches MSG_ADDR into TX_ADDR, len=wr_ptr, rd_ptr=0, retry_cnt=0, sets BUSY, and moves to REQ. START with an empty buffer, or while BUSY, is ignored.
- REQ: TX_REQ=1, TX_DATA=buf[rd_ptr], TX_PEND=(rd_ptr≠len-1). On TX_ACK=1: TX_REQ←0, rd_ptr++, go to ACK_LOW.
- ACK_LOW: TX_REQ=0. Wait for TX_ACK=0. Then go to REQ if rd_ptr<len, else WAIT_RESP. Next-word TX_REQ must rise within 2 cycles of TX_ACK falling, because the node samples it in the last data bit.
- WAIT_RESP: hold until TX_SUCC or TX_FAIL.
- In any non-IDLE state, TX_SUCC or TX_FAIL high forces TX_REQ←0 and moves to RESP. This covers underflow and error fail mid-message.
- RESP: TX_RESP_ACK=1 until TX_SUCC=0 and TX_FAIL=0, then TX_RESP_ACK←0 and:
  - success: DONE=1, STATUS=00, wr_ptr←0, IDLE.
  - fail with retry_cnt<MAX_RETRY: retry_cnt++, rd_ptr←0, REQ. The buffer is retained.
  - fail with retry exhausted: DONE=1, STATUS=01, wr_ptr←0, IDLE.
- Both TX_SUCC and TX_FAIL high in the same cycle is treated as fail.
- Lost arbitration is invisible here: TX_REQ simply stays high until TX_ACK.
- BUSY=1 from the cycle after START until the cycle of DONE inclusive.
- TX_ADDR, TX_DATA, and TX_PEND are registered and stable while TX_REQ=1.

Optional Feature:
ULPB_TX_TIMEOUT_EN:
- Defined: a counter of log2(TIMEOUT)+1 bits clears on entry to REQ and increments while in REQ with TX_ACK=0. Reaching TIMEOUT drops TX_REQ and ends with DONE, STATUS=10, wr_ptr←0, IDLE. No retry is attempted.
- Undefined: no counter; REQ waits indefinitely, and STATUS=10 is never produced.

Decomposition:
- Shared package/include (alongside ulpb_def.v): STATUS codes, sequencer state encodings, log2 function (existing func include).
- One natural sub-module: ulpb_tx_buf, a DEPTH×`DATA_WIDTH single-write/single-read register array with a combinational read.

Test Plan:
1. Write 1 word 0xDEADBEEF, MSG_ADDR=0x12, START; node acks and TX_SUCC -> TX_PEND=0, TX_DATA=0xDEADBEEF, TX_RESP_ACK held until TX_SUCC low, DONE with STATUS=00, FULL=0.
2. Write 3 words (0x1,0x2,0x3), START -> TX_PEND sequence 1,1,0; each TX_REQ rises ≤2 cycles after TX_ACK falls; DONE with STATUS=00.
3. 2-word message; TX_FAIL after the final word, twice, then TX_SUCC -> replays from word 0 each time, DONE with STATUS=00 after the 3rd attempt. With four TX_FAILs -> DONE with STATUS=01 after 3 attempts.
4. Write 8 words -> FULL=1 and a 9th WR_EN is dropped; WR_EN while BUSY is dropped; START while BUSY or with an empty buffer produces no DONE.
5. TX_FAIL asserted while in REQ on word 2 of 4 -> TX_REQ low next cycle, retry from word 0.
6. With ULPB_TX_TIMEOUT_EN and TIMEOUT=16, TX_ACK never asserted -> TX_REQ drops and DONE with STATUS=10 at cycle 16 of REQ. RESET asserted mid-message -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/ulpb_tx_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ulpb_tx_sequencer_pkg
// Shared definitions for the bus-node transmit sequencer:
//   - bus word/address widths used by the node interface
//   - completion status codes reported with DONE
//   - sequencer state encoding
//   - ulpb_log2(): ceiling log2, used to size pointers and counters
// ---------------------------------------------------------------------------
package ulpb_tx_sequencer_pkg;

    // Node interface widths
    localparam int ULPB_DATA_WIDTH = 32;
    localparam int ULPB_ADDR_WIDTH = 8;

    // Completion status, valid in the DONE cycle
    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_FAIL    = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_ACK_LOW   = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_RESP      = 3'd4
    } ulpb_seq_state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int ulpb_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ulpb_tx_buf.sv
// ---------------------------------------------------------------------------
// ulpb_tx_buf
// Message word buffer: DEPTH words, one write port, one combinational read
// port. Contents are not reset.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write word index
//   i_wr_data  write data
//   i_rd_addr  read word index
//   o_rd_data  read data (combinational from i_rd_addr)
// ---------------------------------------------------------------------------
module ulpb_tx_buf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] w_words [DEPTH];

    // One register per word, each with its own decoded write enable.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] r_word;

            always_ff @(posedge i_clk) begin
                if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
                    r_word <= i_wr_data;
                end
            end

            assign w_words[gi] = r_word;
        end
    endgenerate

    assign o_rd_data = w_words[i_rd_addr];

endmodule

// File: rtl/ulpb_tx_sequencer.sv
// ---------------------------------------------------------------------------
// ulpb_tx_sequencer
// Feeds one buffered message (address + 1..DEPTH data words) into the bus
// node's transmit handshake, consumes the node's success/fail response,
// replays failed messages up to MAX_RETRY times and reports completion with
// a one-cycle DONE plus STATUS.
//
// Optional feature (compile-time macro ULPB_TX_TIMEOUT_EN):
//   defined   - a word left unacknowledged for TIMEOUT cycles in REQ aborts
//               the message with STATUS=10 (no retry)
//   undefined - REQ waits indefinitely for TX_ACK
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_wr_en, i_wr_data    buffer load (accepted only when idle and not full)
//   o_full                buffer holds DEPTH words
//   i_msg_addr, i_start   destination address and send request
//   o_busy                message in progress (through the DONE cycle)
//   o_done, o_status      completion pulse and code (00 ok/01 fail/10 timeout)
//   o_tx_addr, o_tx_data  word presented to the node
//   o_tx_pend             more words follow the current one
//   o_tx_req, i_tx_ack    word handshake
//   i_tx_succ, i_tx_fail  node response
//   o_tx_resp_ack         response acknowledge
// ---------------------------------------------------------------------------
module ulpb_tx_sequencer
    import ulpb_tx_sequencer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wr_en,
    input  logic [ULPB_DATA_WIDTH-1:0] i_wr_data,
    output logic                       o_full,
    input  logic [ULPB_ADDR_WIDTH-1:0] i_msg_addr,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [1:0]                 o_status,
    output logic [ULPB_ADDR_WIDTH-1:0] o_tx_addr,
    output logic [ULPB_DATA_WIDTH-1:0] o_tx_data,
    output logic                       o_tx_pend,
    output logic                       o_tx_req,
    input  logic                       i_tx_ack,
    input  logic                       i_tx_succ,
    input  logic                       i_tx_fail,
    output logic                       o_tx_resp_ack
);

    localparam int PTR_W   = ulpb_log2(DEPTH) + 1;
    localparam int IDX_W   = PTR_W - 1;
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : ulpb_log2(MAX_RETRY + 1);

    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]   PTR_FULL  = PTR_W'(DEPTH);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    ulpb_seq_state_t             r_state;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [PTR_W-1:0]            r_len;
    logic [RETRY_W-1:0]          r_retry_cnt;
    logic                        r_fail_seen;
    logic [ULPB_ADDR_WIDTH-1:0]  r_tx_addr;
    logic [ULPB_DATA_WIDTH-1:0]  r_tx_data;
    logic                        r_tx_pend;
    logic                        r_tx_req;
    logic                        r_tx_resp_ack;
    logic                        r_busy;
    logic                        r_done;
    logic [1:0]                  r_status;

    logic                        w_full;
    logic                        w_idle;
    logic                        w_wr_accept;
    logic                        w_start_accept;
    logic                        w_in_msg;
    logic                        w_resp_in;
    logic                        w_timeout;
    logic [IDX_W-1:0]            w_rd_idx;
    logic [ULPB_DATA_WIDTH-1:0]  w_rd_data;

    assign w_full    = (r_wr_ptr == PTR_FULL);
    // The DONE cycle is already IDLE but still BUSY; keep the controller
    // side closed until BUSY has dropped.
    assign w_idle    = (r_state == ST_IDLE) && !r_busy;
    assign w_wr_accept    = i_wr_en && w_idle && !w_full;
    assign w_start_accept = i_start && w_idle && (r_wr_ptr != '0);
    assign w_in_msg  = (r_state == ST_REQ) || (r_state == ST_ACK_LOW) ||
                       (r_state == ST_WAIT_RESP);
    assign w_resp_in = i_tx_succ | i_tx_fail;

    // TX_DATA is registered together with the rising TX_REQ, so the buffer is
    // read at the index of the word about to be presented: rd_ptr when moving
    // on from ACK_LOW, word 0 when starting or replaying.
    assign w_rd_idx = (r_state == ST_ACK_LOW) ? r_rd_ptr[IDX_W-1:0] : '0;

    ulpb_tx_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (ULPB_DATA_WIDTH),
        .ADDR_W (IDX_W)
    ) u_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[IDX_W-1:0]),
        .i_wr_data (i_wr_data),
        .i_rd_addr (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // -----------------------------------------------------------------------
    // Optional TX_ACK timeout
    // -----------------------------------------------------------------------
`ifdef ULPB_TX_TIMEOUT_EN
    localparam int TO_W = ulpb_log2(TIMEOUT) + 1;

    logic [TO_W-1:0] r_to_cnt;

    // REQ is never re-entered from itself, so holding the counter at zero
    // outside REQ gives a clear on every entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_REQ) begin
            r_to_cnt <= '0;
        end else if (!i_tx_ack) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Fires at the end of the TIMEOUT-th unacknowledged REQ cycle.
    assign w_timeout = (r_state == ST_REQ) && !i_tx_ack &&
                       (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_len         <= '0;
            r_retry_cnt   <= '0;
            r_fail_seen   <= 1'b0;
            r_tx_addr     <= '0;
            r_tx_data     <= '0;
            r_tx_pend     <= 1'b0;
            r_tx_req      <= 1'b0;
            r_tx_resp_ack <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            // A response can arrive at any point of the message (underflow,
            // error) and always ends the current attempt. Both flags high
            // counts as a fail.
            if (w_in_msg && w_resp_in) begin
                r_tx_req      <= 1'b0;
                r_tx_resp_ack <= 1'b1;
                r_fail_seen   <= i_tx_fail;
                r_state       <= ST_RESP;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Drops BUSY the cycle after DONE.
                        r_busy <= 1'b0;
                        if (w_start_accept) begin
                            r_tx_addr   <= i_msg_addr;
                            r_len       <= r_wr_ptr;
                            r_rd_ptr    <= '0;
                            r_retry_cnt <= '0;
                            r_busy      <= 1'b1;
                            r_tx_data   <= w_rd_data;
                            r_tx_pend   <= (r_wr_ptr != PTR_ONE);
                            r_tx_req    <= 1'b1;
                            r_state     <= ST_REQ;
                        end
                    end

                    ST_REQ: begin
                        if (i_tx_ack) begin
                            r_tx_req <= 1'b0;
                            r_rd_ptr <= r_rd_ptr + PTR_ONE;
                            r_state  <= ST_ACK_LOW;
                        end else if (w_timeout) begin
                            r_tx_req <= 1'b0;
                            r_done   <= 1'b1;
                            r_status <= STATUS_TIMEOUT;
                            r_wr_ptr <= '0;
                            r_state  <= ST_IDLE;
                        end
                    end

                    ST_ACK_LOW: begin
                        // The next TX_REQ rises on the same edge that sees
                        // TX_ACK low, well inside the node's sampling window.
                        if (!i_tx_ack) begin
                            if (r_rd_ptr < r_len) begin
                                r_tx_data <= w_rd_data;
                                r_tx_pend <= (r_rd_ptr != (r_len - PTR_ONE));
                                r_tx_req  <= 1'b1;
                                r_state   <= ST_REQ;
                            end else begin
                                r_state <= ST_WAIT_RESP;
                            end
                        end
                    end

                    ST_WAIT_RESP: begin
                        // Left only through the response check above.
                        r_state <= ST_WAIT_RESP;
                    end

                    ST_RESP: begin
                        r_fail_seen <= r_fail_seen | i_tx_fail;
                        if (!w_resp_in) begin
                            r_tx_resp_ack <= 1'b0;
                            if (!r_fail_seen) begin
                                r_done   <= 1'b1;
                                r_status <= STATUS_OK;
                                r_wr_ptr <= '0;
                                r_state  <= ST_IDLE;
                            end else if (r_retry_cnt < RETRY_MAX) begin
                                // Replay from word 0; buffer and len retained.
                                r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                                r_rd_ptr    <= '0;
                                r_tx_data   <= w_rd_data;
                                r_tx_pend   <= (r_len != PTR_ONE);
                                r_tx_req    <= 1'b1;
                                r_state     <= ST_REQ;
                            end else begin
                                r_done   <= 1'b1;
                                r_status <= STATUS_FAIL;
                                r_wr_ptr <= '0;
                                r_state  <= ST_IDLE;
                            end
                        end
                    end

                    default: begin
                        r_tx_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_full        = w_full;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_status      = r_status;
    assign o_tx_addr     = r_tx_addr;
    assign o_tx_data     = r_tx_data;
    assign o_tx_pend     = r_tx_pend;
    assign o_tx_req      = r_tx_req;
    assign o_tx_resp_ack = r_tx_resp_ack;

endmodule

// File: tb/tb_ulpb_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ulpb_tx_sequencer
// Self-checking bench for ulpb_tx_sequencer. A table of message vectors is
// loaded, sent and answered by a small node responder; expected words and
// completion codes go to scoreboard queues at START and are popped as the
// sequencer presents them. Hand-written sequences cover reset, empty START,
// reset mid-message and (with ULPB_TX_TIMEOUT_EN) the ACK timeout.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ulpb_tx_sequencer;
    import ulpb_tx_sequencer_pkg::*;

    localparam int DEPTH     = 8;
    localparam int MAX_RETRY = 2;
`ifdef ULPB_TX_TIMEOUT_EN
    localparam int TIMEOUT   = 16;
`else
    localparam int TIMEOUT   = 1024;
`endif
    localparam int NVEC = 7;

    logic        clk = 1'b0;
    logic        srst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        o_full;
    logic [7:0]  msg_addr;
    logic        start;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_status;
    logic [7:0]  o_tx_addr;
    logic [31:0] o_tx_data;
    logic        o_tx_pend;
    logic        o_tx_req;
    logic        ack;
    logic        succ;
    logic        fail;
    logic        o_tx_resp_ack;

    always #5 clk = ~clk;

    ulpb_tx_sequencer #(
        .DEPTH     (DEPTH),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (srst),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_full        (o_full),
        .i_msg_addr    (msg_addr),
        .i_start       (start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_status      (o_status),
        .o_tx_addr     (o_tx_addr),
        .o_tx_data     (o_tx_data),
        .o_tx_pend     (o_tx_pend),
        .o_tx_req      (o_tx_req),
        .i_tx_ack      (ack),
        .i_tx_succ     (succ),
        .i_tx_fail     (fail),
        .o_tx_resp_ack (o_tx_resp_ack)
    );

    typedef struct packed {
        int          nwords;
        logic [7:0]  addr;
        logic [31:0] base;          // word k = base + k
        int          nfail;         // end-of-message fails before success
        logic        mid_fail;      // attempt 0 fails while word 1 is requested
        logic        both_hi;       // fail responses also raise TX_SUCC
        int          exp_attempts;
        logic [1:0]  exp_status;
    } msg_vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        pend;
        int          attempt;
        int          idx;
    } exp_word_t;

    msg_vec_t   vecs [NVEC];
    exp_word_t  exp_q [$];
    logic [1:0] stat_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_tx_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: got no TX_REQ within 20 cycles expected TX_REQ=1 (t=%0t)", $time);
        end
    endtask

    task automatic run_vec(input int v);
        msg_vec_t    m;
        logic [31:0] bufm [$];
        exp_word_t   e;
        bit          ok;
        bit          seen;
        bit          is_fail;
        bit          mid_done;
        m = vecs[v];
        exp_q.delete();
        stat_q.delete();

        // Load the buffer
        for (int i = 0; i < m.nwords; i++) begin
            wr_en   = 1'b1;
            wr_data = m.base + 32'(i);
            bufm.push_back(wr_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("full_after_load", o_full, (m.nwords == DEPTH));
        if (m.nwords == DEPTH) begin
            wr_en   = 1'b1;
            wr_data = 32'hBAD0BAD0;
            @(negedge clk);
            wr_en = 1'b0;
            chk("full_after_overflow", o_full, 1);
        end

        // START; the address input moves away to prove it was latched
        msg_addr = m.addr;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        msg_addr = ~m.addr;
        chk("busy_after_start", o_busy, 1);

        for (int a = 0; a < m.exp_attempts; a++) begin
            int last;
            last = (a == 0 && m.mid_fail) ? 1 : m.nwords - 1;
            for (int k = 0; k <= last; k++) begin
                e.data    = bufm[k];
                e.pend    = (k != m.nwords - 1);
                e.attempt = a;
                e.idx     = k;
                exp_q.push_back(e);
            end
        end
        stat_q.push_back(m.exp_status);

        for (int a = 0; a < m.exp_attempts; a++) begin
            mid_done = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].attempt == a) begin
                wait_req(ok);
                if (!ok) return;
                e = exp_q.pop_front();
                chk("tx_data", o_tx_data, e.data);
                chk("tx_pend", o_tx_pend, e.pend);
                chk("tx_addr", o_tx_addr, m.addr);
                if (a == 0 && e.idx == 0) begin
                    // Write and START while busy must both be ignored
                    wr_en   = 1'b1;
                    wr_data = 32'h5A5A5A5A;
                    start   = 1'b1;
                end
                if (m.mid_fail && a == 0 && e.idx == 1) begin
                    fail = 1'b1;
                    @(negedge clk);
                    chk("mid_req_drop", o_tx_req, 0);
                    chk("mid_resp_ack", o_tx_resp_ack, 1);
                    fail = 1'b0;
                    @(negedge clk);
                    chk("mid_resp_release", o_tx_resp_ack, 0);
                    chk("mid_no_done", o_done, 0);
                    mid_done = 1'b1;
                end else begin
                    ack = 1'b1;
                    @(negedge clk);
                    wr_en = 1'b0;
                    start = 1'b0;
                    chk("req_drop", o_tx_req, 0);
                    chk("full_while_busy", o_full, (m.nwords == DEPTH));
                    ack = 1'b0;
                    if (e.pend) begin
                        seen = 1'b0;
                        for (int c = 0; c < 2; c++) begin
                            @(negedge clk);
                            if (o_tx_req) begin
                                seen = 1'b1;
                                break;
                            end
                        end
                        chk("req_rise_2cyc", seen, 1);
                    end else begin
                        @(negedge clk);
                        chk("req_low_after_last", o_tx_req, 0);
                    end
                end
            end

            if (!mid_done) begin
                is_fail = (a < m.nfail);
                fail = is_fail;
                succ = !is_fail || m.both_hi;
                @(negedge clk);
                chk("resp_ack_rise", o_tx_resp_ack, 1);
                chk("resp_req_low", o_tx_req, 0);
                @(negedge clk);
                chk("resp_ack_hold", o_tx_resp_ack, 1);
                succ = 1'b0;
                fail = 1'b0;
                @(negedge clk);
                chk("resp_ack_fall", o_tx_resp_ack, 0);
                if (a == m.exp_attempts - 1) begin
                    chk("done", o_done, 1);
                    chk("status", o_status, stat_q.pop_front());
                    chk("busy_at_done", o_busy, 1);
                    @(negedge clk);
                    chk("done_pulse", o_done, 0);
                    chk("busy_after_done", o_busy, 0);
                end else begin
                    chk("retry_no_done", o_done, 0);
                end
            end
        end

        repeat (3) begin
            @(negedge clk);
            chk("quiet_after_done", {o_done, o_tx_req}, 0);
        end
        $display("msg %0d: words=%0d addr=0x%0h attempts=%0d status=%0b",
                 v, m.nwords, m.addr, m.exp_attempts, m.exp_status);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 8'h12, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1, 2'b00};
        vecs[1] = '{3, 8'h34, 32'h00000001, 0, 1'b0, 1'b0, 1, 2'b00};
        vecs[2] = '{2, 8'h56, 32'hC0DE0000, 2, 1'b0, 1'b0, 3, 2'b00};
        vecs[3] = '{2, 8'h78, 32'hF00D0000, 4, 1'b0, 1'b1, 3, 2'b01};
        vecs[4] = '{4, 8'h9A, 32'h44440000, 0, 1'b1, 1'b0, 2, 2'b00};
        vecs[5] = '{7, 8'hBC, 32'h77770000, 1, 1'b0, 1'b0, 2, 2'b00};
        vecs[6] = '{8, 8'hDE, 32'h88880000, 0, 1'b0, 1'b0, 1, 2'b00};

        srst = 1'b1; wr_en = 1'b0; wr_data = '0; msg_addr = '0; start = 1'b0;
        ack = 1'b0; succ = 1'b0; fail = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_tx_req, o_busy, o_done, o_status, o_full, o_tx_resp_ack, o_tx_pend}, 0);
        srst = 1'b0;
        @(negedge clk);
        chk("post_reset_addr_data", {o_tx_addr, o_tx_data}, 0);
        $display("reset: outputs idle");

        // START with an empty buffer is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            chk("empty_start_quiet", {o_busy, o_tx_req, o_done}, 0);
            @(negedge clk);
        end
        $display("empty start: ignored");

        // Reset mid-message drops everything on the next edge
        for (int k = 0; k < 3; k++) begin
            wr_en   = 1'b1;
            wr_data = 32'hAB000000 + 32'(k);
            @(negedge clk);
        end
        wr_en    = 1'b0;
        msg_addr = 8'h3C;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_req", o_tx_req, 1);
        srst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", {o_tx_req, o_busy, o_done, o_status, o_full, o_tx_resp_ack, o_tx_pend}, 0);
        chk("mid_reset_addr_data", {o_tx_addr, o_tx_data}, 0);
        srst = 1'b0;
        @(negedge clk);
        $display("reset mid-message: outputs cleared");

        for (int v = 0; v < NVEC; v++) begin
            run_vec(v);
        end

`ifdef ULPB_TX_TIMEOUT_EN
        begin
            int  cnt;
            bit  seen;
            wr_en   = 1'b1;
            wr_data = 32'h70707070;
            @(negedge clk);
            wr_en    = 1'b0;
            msg_addr = 8'h77;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cnt  = 0;
            seen = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (o_done) begin
                    seen = 1'b1;
                    break;
                end
                if (o_tx_req) cnt++;
                @(negedge clk);
            end
            chk("to_done", seen, 1);
            chk("to_status", o_status, 2'b10);
            chk("to_req_cycles", cnt, TIMEOUT);
            chk("to_req_low", o_tx_req, 0);
            @(negedge clk);
            chk("to_idle", {o_busy, o_done}, 0);
            $display("timeout: req cycles=%0d status=%0b", cnt, o_status);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
